// File: rtl/jzjpcc_immediate_pipe.sv
// Decode-to-execute immediate stage.
//
// Forms the RISC-V immediate (I/S/B/U/J, optionally CSR zimm) for XLEN 32 or 64,
// precomputes pc+immB and pc+immJ, and registers the result in a 2-entry skid
// buffer (head drives out_*, skid absorbs one extra beat while head is stalled).
//
// Ports:
//   clock            core clock, rising edge
//   reset_n          asynchronous active-low reset
//   in_valid/in_ready  upstream handshake; in_ready = !skid_valid (registered)
//   instruction      instruction bits [31:2]
//   pc               PC of the instruction
//   flush            synchronous squash of both entries, drops any input
//   out_valid/out_ready  downstream handshake on the head entry
//   out_immediate    selected sign/zero-extended immediate
//   out_immType      0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 ZIMM
//   out_branchTarget pc + immB (mod 2^XLEN)
//   out_jumpTarget   pc + immJ (mod 2^XLEN)
//   out_illegal      opcode not in the supported set
//
// Build option:
//   JZJPCC_CSR_ZIMM_EN  when defined, SYSTEM with instruction[14]=1 yields the
//                       zero-extended zimm (instruction[19:15]) as type 6.

module jzjpcc_immediate_pipe #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:2]     instruction,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_immediate,
  output logic [2:0]      out_immType,
  output logic [XLEN-1:0] out_branchTarget,
  output logic [XLEN-1:0] out_jumpTarget,
  output logic            out_illegal
);

  localparam logic [2:0] ImmNone = 3'd0;
  localparam logic [2:0] ImmI    = 3'd1;
  localparam logic [2:0] ImmS    = 3'd2;
  localparam logic [2:0] ImmB    = 3'd3;
  localparam logic [2:0] ImmU    = 3'd4;
  localparam logic [2:0] ImmJ    = 3'd5;
  localparam logic [2:0] ImmZimm = 3'd6;

  localparam logic [4:0] OpLoad    = 5'b00000;
  localparam logic [4:0] OpMiscMem = 5'b00011;
  localparam logic [4:0] OpOpImm   = 5'b00100;
  localparam logic [4:0] OpAuipc   = 5'b00101;
  localparam logic [4:0] OpStore   = 5'b01000;
  localparam logic [4:0] OpOp      = 5'b01100;
  localparam logic [4:0] OpLui     = 5'b01101;
  localparam logic [4:0] OpBranch  = 5'b11000;
  localparam logic [4:0] OpJalr    = 5'b11001;
  localparam logic [4:0] OpJal     = 5'b11011;
  localparam logic [4:0] OpSystem  = 5'b11100;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_type;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jmp_target;
    logic            illegal;
  } payload_t;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [4:0]  opcode;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [2:0]  dec_type;
  logic        dec_illegal;
  logic [31:0] dec_imm32;
  payload_t    dec;

  assign opcode = instruction[6:2];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  always_comb begin
    dec_type    = ImmNone;
    dec_illegal = 1'b0;
    case (opcode)
      OpLoad, OpOpImm, OpJalr, OpMiscMem: dec_type = ImmI;
      OpSystem: begin
        dec_type = ImmI;
`ifdef JZJPCC_CSR_ZIMM_EN
        // CSRR*I variants carry a 5-bit unsigned operand in the rs1 field.
        if (instruction[14]) dec_type = ImmZimm;
`endif
      end
      OpStore:        dec_type = ImmS;
      OpBranch:       dec_type = ImmB;
      OpLui, OpAuipc: dec_type = ImmU;
      OpJal:          dec_type = ImmJ;
      OpOp:           dec_type = ImmNone;
      default:        dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    dec_imm32 = '0;
    case (dec_type)
      ImmI:    dec_imm32 = imm_i;
      ImmS:    dec_imm32 = imm_s;
      ImmB:    dec_imm32 = imm_b;
      ImmU:    dec_imm32 = imm_u;
      ImmJ:    dec_imm32 = imm_j;
      ImmZimm: dec_imm32 = {27'b0, instruction[19:15]};
      default: dec_imm32 = '0;
    endcase
  end

  // All 32-bit forms sign-extend from bit 31; zimm has bit 31 clear so the same
  // extension yields its zero-extension.
  always_comb begin
    dec.imm        = XLEN'($signed(dec_imm32));
    dec.imm_type   = dec_type;
    dec.br_target  = pc + XLEN'($signed(imm_b));
    dec.jmp_target = pc + XLEN'($signed(imm_j));
    dec.illegal    = dec_illegal;
  end

  // ---------------------------------------------------------------------------
  // Two-entry skid buffer
  // ---------------------------------------------------------------------------
  payload_t head_q, head_d, skid_q, skid_d;
  logic     head_valid_q, head_valid_d;
  logic     skid_valid_q, skid_valid_d;
  logic     accept;

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;

  always_comb begin
    head_d       = head_q;
    skid_d       = skid_q;
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      // Payload is left untouched; only the valid bits are cleared.
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low, so nothing can be accepted; only the skid can advance.
      if (out_ready) begin
        head_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (!head_valid_q || out_ready) begin
      head_valid_d = accept;
      if (accept) head_d = dec;
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q       <= '0;
      skid_q       <= '0;
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      skid_q       <= skid_d;
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid        = head_valid_q;
  assign out_immediate    = head_q.imm;
  assign out_immType      = head_q.imm_type;
  assign out_branchTarget = head_q.br_target;
  assign out_jumpTarget   = head_q.jmp_target;
  assign out_illegal      = head_q.illegal;

  // The skid only ever fills behind a stalled head.
  skid_implies_head: assert property (@(posedge clock) disable iff (!reset_n)
    skid_valid_q |-> head_valid_q);

endmodule
